vga_buffer_arbiter: RTL and testbench
=====================================

VGA_BUFFER_ARBITER -- requirements
Module: vga_buffer_arbiter

Interface
REQ-001 SHALL have parameter IMAGE_ROW, default 240, number of pixel rows in the frame buffer.
REQ-002 SHALL have parameter IMAGE_COL, default 320, number of pixel columns in the frame buffer.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, consecutive cycles of write stall before a write is forced.
REQ-004 SHALL have `clk  input  1`, the single clock; all logic updates on its rising edge.
REQ-005 SHALL have `rst  input  1`, reset; asynchronous and active-high.
REQ-006 SHALL have write-side ports from the masking pipeline:
- `wr_valid  in  1` (pixel offered)
- `wr_ready  out  1` (write granted this cycle)
- `wr_row  in  8`
- `wr_col  in  9`
- `wr_pixel  in  12` (RGB444)
REQ-007 SHALL have read-side ports from the VGA controller:
- `rd_req  in  1`
- `rd_ready  out  1` (read granted this cycle)
- `rd_row  in  8`
- `rd_col  in  9`
- `rd_valid  out  1`
- `rd_pixel  out  12`
REQ-008 SHALL have RAM-side ports to a single-port synchronous buffer RAM:
- `ram_addr  out  17`
- `ram_we  out  1`
- `ram_wdata  out  12`
- `ram_rdata  in  12` (valid one edge after address)
REQ-009 SHALL have status ports:
- `frame_done  out  1` (one-cycle pulse)
- `oob_err  out  1` (sticky)
- `pix_count  out  17` (accepted in-range writes in the current frame)

Function
REQ-010 SHALL compute the linear address as row*IMAGE_COL + col at 17-bit width with no truncation; concatenation or row*col forms are forbidden.
REQ-011 SHALL grant exactly one requester per cycle: read wins when rd_req=1, unless force_wr=1.
REQ-012 SHALL generate force_wr as a registered flag: set when starve_cnt reaches STARVE_LIMIT-1 while wr_valid=1 and wr_ready=0; cleared by any accepted write.
REQ-013 SHALL drive both grants combinationally:
- rd_ready = rd_req & ~force_wr
- wr_ready = ~rd_ready
REQ-014 SHALL treat a transfer as accepted at a rising edge where valid/req and ready are both 1.
REQ-015 SHALL manage starve_cnt (5 bits, saturating) as follows: increment each cycle wr_valid=1 and wr_ready=0; clear on an accepted write or when wr_valid=0.
REQ-016 SHALL register RAM commands in a 3-state FSM {IDLE, RD, WR}.
- Accepted read: next state RD, ram_addr=address, ram_we=0.
- Accepted in-range write: next state WR, ram_addr=address, ram_wdata=wr_pixel, ram_we=1.
- Otherwise: IDLE, ram_we=0, ram_addr holds its value.
REQ-017 SHALL give reads a fixed latency of 2 edges: for rd_req accepted at edge k, rd_pixel captures ram_rdata at edge k+2 and rd_valid=1 for exactly the following cycle.
REQ-018 SHALL accept back-to-back reads every cycle, so rd_valid may stay high continuously.
REQ-019 SHALL treat a write with wr_row>=IMAGE_ROW or wr_col>=IMAGE_COL as out-of-bounds:
- the write is accepted (consumed), with no RAM write and no pix_count change;
- oob_err is set and stays set until reset.
REQ-020 SHALL treat an out-of-range read as accepted: RAM is not accessed and rd_valid is returned at normal latency with rd_pixel=12'h000.
REQ-021 SHALL increment pix_count on each accepted in-range write. When the increment would reach IMAGE_ROW*IMAGE_COL, pix_count wraps to 0 and frame_done pulses high the next cycle.
REQ-022 SHALL leave a read issued to the same address in the cycle after a write to RAM semantics; the arbiter adds no forwarding.

Reset
REQ-023 SHALL, while rst=1, immediately force:
- FSM=IDLE, ram_we=0, ram_addr=0, ram_wdata=0
- rd_valid=0, rd_pixel=0, frame_done=0, oob_err=0
- pix_count=0, starve_cnt=0, force_wr=0
REQ-024 SHALL discard all in-flight reads when rst asserts mid-operation; no rd_valid is produced for them after reset release.
REQ-025 SHALL hold wr_ready and rd_ready at 0 while rst=1.

Verification
REQ-026 SHALL cover single write: wr_row=2, wr_col=5, wr_pixel=12'hABC, rd_req=0 -> one cycle later ram_we=1, ram_addr=645, ram_wdata=12'hABC; pix_count=1.
REQ-027 SHALL cover read latency: rd_req at edges k..k+3 for (0,0),(0,1),(0,2),(0,3) with ram model returning address -> rd_valid high for cycles after k+2..k+5, rd_pixel=0,1,2,3.
REQ-028 SHALL cover starvation: rd_req held 1 and wr_valid=1 from cycle 0 -> the write is accepted exactly once within STARVE_LIMIT+1 cycles (rd_ready=0 that cycle), then reads resume.
REQ-029 SHALL cover out-of-bounds: write (240,0) then (0,320) -> ram_we stays 0, oob_err=1 and sticky, pix_count unchanged; read (239,400) -> rd_valid with rd_pixel=0.
REQ-030 SHALL cover frame wrap: 76800 in-range writes -> pix_count returns to 0 and frame_done is a single one-cycle pulse.
REQ-031 SHALL cover reset mid-read: assert rst one cycle after an accepted read -> all outputs at reset values immediately, and no rd_valid after rst deasserts.

Source files
------------

// File: rtl/vga_buffer_arbiter_if.sv
// Bus bundle for the VGA frame-buffer arbiter: write side, read side,
// RAM command/data side and status. slave = arbiter, master = its environment.
interface vga_buffer_arbiter_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_row;
  logic [8:0]  wr_col;
  logic [11:0] wr_pixel;

  logic        rd_req;
  logic        rd_ready;
  logic [7:0]  rd_row;
  logic [8:0]  rd_col;
  logic        rd_valid;
  logic [11:0] rd_pixel;

  logic [16:0] ram_addr;
  logic        ram_we;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;

  logic        frame_done;
  logic        oob_err;
  logic [16:0] pix_count;

  modport slave (
    input  wr_valid, wr_row, wr_col, wr_pixel,
    output wr_ready,
    input  rd_req, rd_row, rd_col,
    output rd_ready, rd_valid, rd_pixel,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata,
    output frame_done, oob_err, pix_count
  );

  modport master (
    output wr_valid, wr_row, wr_col, wr_pixel,
    input  wr_ready,
    output rd_req, rd_row, rd_col,
    input  rd_ready, rd_valid, rd_pixel,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata,
    input  frame_done, oob_err, pix_count
  );
endinterface

// File: rtl/vga_buffer_arbiter.sv
// Single-port frame-buffer arbiter: one read or write grant per cycle,
// starvation-forced writes, 2-edge read latency, frame/oob status.
// Ports: clk, rst (async, active-high), bus (vga_buffer_arbiter_if.slave).
module vga_buffer_arbiter #(
  parameter int IMAGE_ROW    = 240,
  parameter int IMAGE_COL    = 320,
  parameter int STARVE_LIMIT = 8
) (
  input logic                 clk,
  input logic                 rst,
  vga_buffer_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  localparam logic [8:0]  ROW_LIM = 9'(IMAGE_ROW);
  localparam logic [9:0]  COL_LIM = 10'(IMAGE_COL);
  localparam logic [16:0] COLS    = 17'(IMAGE_COL);
  localparam logic [16:0] LAST    = 17'(IMAGE_ROW * IMAGE_COL - 1);
  localparam logic [4:0]  S_LIM   = 5'(STARVE_LIMIT - 1);

  state_t      state;
  logic [4:0]  starve_cnt;
  logic        force_wr;
  logic        rd_zero1;
  logic        rd_p2;
  logic        rd_zero2;

  logic [16:0] wr_addr;
  logic [16:0] rd_addr;
  logic        wr_in;
  logic        rd_in;
  logic        wr_acc;
  logic        rd_acc;

  assign wr_addr = 17'(bus.wr_row) * COLS + 17'(bus.wr_col);
  assign rd_addr = 17'(bus.rd_row) * COLS + 17'(bus.rd_col);

  assign wr_in = ({1'b0, bus.wr_row} < ROW_LIM)
              && ({1'b0, bus.wr_col} < COL_LIM);
  assign rd_in = ({1'b0, bus.rd_row} < ROW_LIM)
              && ({1'b0, bus.rd_col} < COL_LIM);

  // Grants are gated by rst so nothing is granted while in reset.
  assign bus.rd_ready = ~rst & bus.rd_req & ~force_wr;
  assign bus.wr_ready = ~rst & ~bus.rd_ready;

  assign rd_acc = bus.rd_req & bus.rd_ready;
  assign wr_acc = bus.wr_valid & bus.wr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.rd_valid  <= 1'b0;
      bus.rd_pixel  <= '0;
      bus.frame_done <= 1'b0;
      bus.oob_err   <= 1'b0;
      bus.pix_count <= '0;
      starve_cnt    <= '0;
      force_wr      <= 1'b0;
      rd_zero1      <= 1'b0;
      rd_p2         <= 1'b0;
      rd_zero2      <= 1'b0;
    end else begin
      state          <= IDLE;
      bus.ram_we     <= 1'b0;
      bus.frame_done <= 1'b0;

      if (rd_acc) begin
        // Out-of-range reads still occupy the RD slot but leave the
        // RAM address alone; their data is zeroed at capture.
        state    <= RD;
        rd_zero1 <= ~rd_in;
        if (rd_in)
          bus.ram_addr <= rd_addr;
      end else if (wr_acc) begin
        if (wr_in) begin
          state         <= WR;
          bus.ram_we    <= 1'b1;
          bus.ram_addr  <= wr_addr;
          bus.ram_wdata <= bus.wr_pixel;
          if (bus.pix_count == LAST) begin
            bus.pix_count  <= '0;
            bus.frame_done <= 1'b1;
          end else begin
            bus.pix_count <= bus.pix_count + 17'd1;
          end
        end else begin
          bus.oob_err <= 1'b1;
        end
      end

      // Read return: address registered at k, RAM data at k+1,
      // captured at k+2.
      rd_p2    <= (state == RD);
      rd_zero2 <= rd_zero1;
      bus.rd_valid <= rd_p2;
      if (rd_p2)
        bus.rd_pixel <= rd_zero2 ? 12'h000 : bus.ram_rdata;

      if (wr_acc || !bus.wr_valid)
        starve_cnt <= '0;
      else if (starve_cnt != 5'h1f)
        starve_cnt <= starve_cnt + 5'd1;

      if (wr_acc)
        force_wr <= 1'b0;
      else if (bus.wr_valid && !bus.wr_ready && starve_cnt == S_LIM)
        force_wr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_buffer_arbiter.sv
// Directed bench for vga_buffer_arbiter with a read scoreboard
// and a synchronous RAM model.
module tb_vga_buffer_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc;
  bit   echo;

  typedef struct {
    logic [11:0] px;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  logic [11:0] mem [0:131071];

  vga_buffer_arbiter_if ifc ();

  vga_buffer_arbiter #(
    .IMAGE_ROW(240),
    .IMAGE_COL(320),
    .STARVE_LIMIT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (ifc.ram_we)
      mem[ifc.ram_addr] <= ifc.ram_wdata;
    ifc.ram_rdata <= echo ? ifc.ram_addr[11:0] : mem[ifc.ram_addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ifc.rd_valid) begin
      chk("rd_valid_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("rd_pixel", 32'(ifc.rd_pixel), 32'(e.px));
        chk("rd_latency", 32'(cyc), 32'(e.cyc + 3));
      end
    end
  end

  task automatic idle();
    ifc.rd_req   = 1'b0;
    ifc.wr_valid = 1'b0;
  endtask

  task automatic write(input logic [7:0] r, input logic [8:0] c,
                       input logic [11:0] p);
    ifc.rd_req   = 1'b0;
    ifc.wr_valid = 1'b1;
    ifc.wr_row   = r;
    ifc.wr_col   = c;
    ifc.wr_pixel = p;
    #1;
    chk("wr_ready", 32'(ifc.wr_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    ifc.wr_valid = 1'b0;
  endtask

  task automatic rd_step(input logic [7:0] r, input logic [8:0] c,
                         input logic [11:0] exp);
    exp_t e;
    ifc.rd_req = 1'b1;
    ifc.rd_row = r;
    ifc.rd_col = c;
    #1;
    chk("rd_ready", 32'(ifc.rd_ready), 32'd1);
    if (ifc.rd_ready) begin
      e.px  = exp;
      e.cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int   acc;
    int   pulses;
    bit   r;
    bit   w;
    exp_t e;

    checks   = 0;
    failures = 0;
    cyc      = 0;
    echo     = 1'b1;
    rst      = 1'b1;
    ifc.rd_req   = 1'b1;
    ifc.rd_row   = '0;
    ifc.rd_col   = '0;
    ifc.wr_valid = 1'b1;
    ifc.wr_row   = '0;
    ifc.wr_col   = '0;
    ifc.wr_pixel = '0;

    @(negedge clk);
    #1;
    chk("rst_rd_ready", 32'(ifc.rd_ready), 32'd0);
    chk("rst_wr_ready", 32'(ifc.wr_ready), 32'd0);
    chk("rst_ram_we", 32'(ifc.ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ifc.ram_addr), 32'd0);
    chk("rst_rd_valid", 32'(ifc.rd_valid), 32'd0);
    chk("rst_pix_count", 32'(ifc.pix_count), 32'd0);
    chk("rst_oob_err", 32'(ifc.oob_err), 32'd0);
    chk("rst_frame_done", 32'(ifc.frame_done), 32'd0);
    idle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // single write
    write(8'd2, 9'd5, 12'hABC);
    chk("w1_ram_we", 32'(ifc.ram_we), 32'd1);
    chk("w1_ram_addr", 32'(ifc.ram_addr), 32'd645);
    chk("w1_ram_wdata", 32'(ifc.ram_wdata), 32'hABC);
    chk("w1_pix_count", 32'(ifc.pix_count), 32'd1);
    @(negedge clk);
    chk("w1_we_drop", 32'(ifc.ram_we), 32'd0);

    // read back from RAM contents
    echo = 1'b0;
    rd_step(8'd2, 9'd5, 12'hABC);
    idle();
    repeat (4) @(negedge clk);
    echo = 1'b1;

    // back-to-back reads, RAM echoes its address
    rd_step(8'd0, 9'd0, 12'd0);
    rd_step(8'd0, 9'd1, 12'd1);
    rd_step(8'd0, 9'd2, 12'd2);
    rd_step(8'd0, 9'd3, 12'd3);
    idle();
    repeat (4) @(negedge clk);
    chk("b2b_drained", 32'(sb.size()), 32'd0);

    // starvation: reads requested every cycle, write pending
    ifc.rd_req   = 1'b1;
    ifc.rd_row   = 8'd0;
    ifc.rd_col   = 9'd7;
    ifc.wr_valid = 1'b1;
    ifc.wr_row   = 8'd1;
    ifc.wr_col   = 9'd1;
    ifc.wr_pixel = 12'h123;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      #1;
      r = ifc.rd_ready;
      w = ifc.wr_ready;
      if (r) begin
        e.px  = 12'd7;
        e.cyc = cyc;
        sb.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      if (w) begin
        chk("starve_rd_ready", 32'(r), 32'd0);
        acc = i;
        ifc.wr_valid = 1'b0;
        break;
      end
    end
    chk("starve_accept_cycle", 32'(acc), 32'd8);
    chk("starve_ram_we", 32'(ifc.ram_we), 32'd1);
    chk("starve_ram_addr", 32'(ifc.ram_addr), 32'd321);
    chk("starve_pix_count", 32'(ifc.pix_count), 32'd2);
    rd_step(8'd0, 9'd9, 12'd9);
    idle();
    repeat (4) @(negedge clk);

    // out-of-bounds writes and read
    write(8'd240, 9'd0, 12'hFFF);
    chk("oob1_ram_we", 32'(ifc.ram_we), 32'd0);
    chk("oob1_err", 32'(ifc.oob_err), 32'd1);
    chk("oob1_pix_count", 32'(ifc.pix_count), 32'd2);
    write(8'd0, 9'd320, 12'hFFF);
    chk("oob2_ram_we", 32'(ifc.ram_we), 32'd0);
    chk("oob2_pix_count", 32'(ifc.pix_count), 32'd2);
    repeat (3) @(negedge clk);
    chk("oob_sticky", 32'(ifc.oob_err), 32'd1);
    rd_step(8'd239, 9'd400, 12'h000);
    idle();
    repeat (4) @(negedge clk);
    chk("oob_drained", 32'(sb.size()), 32'd0);

    // reset in the cycle after an accepted read
    rd_step(8'd0, 9'd5, 12'd5);
    idle();
    rst = 1'b1;
    sb.delete();
    #1;
    chk("mrst_rd_valid", 32'(ifc.rd_valid), 32'd0);
    chk("mrst_ram_addr", 32'(ifc.ram_addr), 32'd0);
    chk("mrst_oob_err", 32'(ifc.oob_err), 32'd0);
    chk("mrst_pix_count", 32'(ifc.pix_count), 32'd0);
    chk("mrst_rd_pixel", 32'(ifc.rd_pixel), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mrst_no_rd_valid", 32'(ifc.rd_valid), 32'd0);
    end

    // full frame of writes
    do_reset();
    pulses = 0;
    ifc.rd_req   = 1'b0;
    ifc.wr_valid = 1'b1;
    for (int rr = 0; rr < 240; rr++) begin
      for (int cc = 0; cc < 320; cc++) begin
        ifc.wr_row   = 8'(rr);
        ifc.wr_col   = 9'(cc);
        ifc.wr_pixel = 12'(rr + cc);
        if (rr == 239 && cc == 319)
          chk("frame_pre_last", 32'(ifc.pix_count), 32'd76799);
        @(posedge clk);
        @(negedge clk);
        if (ifc.frame_done)
          pulses++;
      end
    end
    ifc.wr_valid = 1'b0;
    chk("frame_done_pulse", 32'(ifc.frame_done), 32'd1);
    chk("frame_pix_wrap", 32'(ifc.pix_count), 32'd0);
    @(negedge clk);
    chk("frame_done_drop", 32'(ifc.frame_done), 32'd0);
    chk("frame_pulse_count", 32'(pulses), 32'd1);

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
